// File: rtl/afpm_pkg.sv
// Shared state encoding and FP16 constants for the multiplier sequencer.
package afpm_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_ISSUE,
    S_WAIT,
    S_OUT_LO,
    S_GAP,
    S_OUT_HI
  } state_t;

endpackage

// File: rtl/afpm_seq_ctrl_if.sv
// Operand, multiplier-core and result-byte signals of the sequencer.
// The slave modport is the controller; master is the surrounding environment.
interface afpm_seq_ctrl_if;
  import afpm_pkg::*;

  logic              in_valid;
  logic [7:0]        in_a;
  logic [7:0]        in_b;
  logic              in_ready;
  logic [FP16_W-1:0] mul_a;
  logic [FP16_W-1:0] mul_b;
  logic              mul_start;
  logic              mul_done;
  logic [FP16_W-1:0] mul_p;
  logic              out_valid;
  logic [7:0]        out_byte;
  logic              out_ready;
  logic              busy;
  logic              error;

  modport master (
    output in_valid, in_a, in_b, mul_done, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, mul_start, out_valid, out_byte, busy, error
  );

  modport slave (
    input  in_valid, in_a, in_b, mul_done, mul_p, out_ready,
    output in_ready, mul_a, mul_b, mul_start, out_valid, out_byte, busy, error
  );

endinterface

// File: rtl/afpm_byte_ser.sv
// Result register and 16-to-8 serializer; the top FSM selects which byte is shown.
// Zero latency from show_* to out_valid; the byte is held as long as show_* stays high.
module afpm_byte_ser
  import afpm_pkg::*;
#(
  parameter int OUT_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [FP16_W-1:0] din,
  input  logic              show_lo,
  input  logic              show_hi,
  input  logic              in_gap,
  output logic              out_valid,
  output logic [7:0]        out_byte,
  output logic              gap_done
);

  // OUT_HOLD == 0 never enters the gap, so the terminal count is irrelevant there.
  localparam logic [1:0] GAP_LAST = 2'((OUT_HOLD > 0) ? OUT_HOLD - 1 : 0);

  logic [FP16_W-1:0] result;
  logic [1:0]        gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      gap_cnt <= '0;
    end else begin
      if (load) result <= din;
      gap_cnt <= in_gap ? gap_cnt + 2'd1 : 2'd0;
    end
  end

  assign out_valid = show_lo | show_hi;
  assign gap_done  = in_gap && (gap_cnt == GAP_LAST);

  always_comb begin
    out_byte = 8'h00;
    if (show_lo)      out_byte = result[7:0];
    else if (show_hi) out_byte = result[15:8];
  end

endmodule

// File: rtl/afpm_seq_ctrl.sv
// Byte-serial front end for an FP16 multiplier core with done-timeout (qNaN on expiry).
// Hi operand byte to first result byte is 3 cycles with a 1-cycle core; out_ready stalls indefinitely.
module afpm_seq_ctrl
  import afpm_pkg::*;
#(
  parameter int DONE_TIMEOUT = 15,
  parameter int OUT_HOLD     = 0
) (
  input logic            clk,
  input logic            rst,
  afpm_seq_ctrl_if.slave bus
);

  localparam int CW = $clog2(DONE_TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [FP16_W-1:0] a_reg;
  logic [FP16_W-1:0] b_reg;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              err_q;
  logic              timeout;
  logic              res_load;
  logic              gap_done;
  logic              show_lo;
  logic              show_hi;
  logic              in_gap;

  // A done pulse on the cycle the counter would expire takes priority over the timeout.
  assign cnt_inc  = cnt + 1'b1;
  assign timeout  = (state == S_WAIT) && !bus.mul_done && (cnt_inc == CW'(DONE_TIMEOUT));
  assign res_load = (state == S_WAIT) && (bus.mul_done || timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.in_valid) state_nxt = S_LOAD_HI;
      S_LOAD_HI: if (bus.in_valid) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (res_load) state_nxt = S_OUT_LO;
      S_OUT_LO:  if (bus.out_ready) state_nxt = (OUT_HOLD > 0) ? S_GAP : S_OUT_HI;
      S_GAP:     if (gap_done) state_nxt = S_OUT_HI;
      S_OUT_HI:  if (bus.out_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.in_valid) begin
        a_reg[7:0] <= bus.in_a;
        b_reg[7:0] <= bus.in_b;
        err_q      <= 1'b0;
      end
      if (state == S_LOAD_HI && bus.in_valid) begin
        a_reg[15:8] <= bus.in_a;
        b_reg[15:8] <= bus.in_b;
      end
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt_inc;
      if (timeout) err_q <= 1'b1;
    end
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE) || (state == S_LOAD_HI);
    bus.mul_start = (state == S_ISSUE);
    bus.busy      = (state != S_IDLE);
    show_lo       = (state == S_OUT_LO);
    show_hi       = (state == S_OUT_HI);
    in_gap        = (state == S_GAP);
  end

  assign bus.mul_a = a_reg;
  assign bus.mul_b = b_reg;
  assign bus.error = err_q;

  afpm_byte_ser #(.OUT_HOLD(OUT_HOLD)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (res_load),
    .din      (bus.mul_done ? bus.mul_p : FP16_QNAN),
    .show_lo  (show_lo),
    .show_hi  (show_hi),
    .in_gap   (in_gap),
    .out_valid(bus.out_valid),
    .out_byte (bus.out_byte),
    .gap_done (gap_done)
  );

endmodule

// File: tb/tb_afpm_seq_ctrl.sv
// Bench for afpm_seq_ctrl: two instances (no gap / two-cycle gap) share stimulus; sel picks the observed one.
module tb_afpm_seq_ctrl;
  import afpm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, mul_done, out_ready, sel;
  logic [7:0]  in_a, in_b;
  logic [15:0] mul_p;

  afpm_seq_ctrl_if bus0 ();
  afpm_seq_ctrl_if bus2 ();

  afpm_seq_ctrl #(.DONE_TIMEOUT(15), .OUT_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  afpm_seq_ctrl #(.DONE_TIMEOUT(15), .OUT_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus0.in_valid = in_valid;  assign bus2.in_valid = in_valid;
  assign bus0.in_a = in_a;          assign bus2.in_a = in_a;
  assign bus0.in_b = in_b;          assign bus2.in_b = in_b;
  assign bus0.mul_done = mul_done;  assign bus2.mul_done = mul_done;
  assign bus0.mul_p = mul_p;        assign bus2.mul_p = mul_p;
  assign bus0.out_ready = out_ready; assign bus2.out_ready = out_ready;

  logic        o_in_ready, o_mul_start, o_out_valid, o_busy, o_error;
  logic [7:0]  o_out_byte;
  logic [15:0] o_mul_a, o_mul_b;
  assign o_in_ready  = sel ? bus2.in_ready  : bus0.in_ready;
  assign o_mul_start = sel ? bus2.mul_start : bus0.mul_start;
  assign o_out_valid = sel ? bus2.out_valid : bus0.out_valid;
  assign o_busy      = sel ? bus2.busy      : bus0.busy;
  assign o_error     = sel ? bus2.error     : bus0.error;
  assign o_out_byte  = sel ? bus2.out_byte  : bus0.out_byte;
  assign o_mul_a     = sel ? bus2.mul_a     : bus0.mul_a;
  assign o_mul_b     = sel ? bus2.mul_b     : bus0.mul_b;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural core: done pulse core_delay cycles after the start pulse (0 = never answers).
  int          core_delay = 0;
  int          core_cnt = 0;
  int          start_count = 0;
  logic [15:0] core_p = '0;
  logic [15:0] exp_a = '0, exp_b = '0;

  initial begin
    mul_done = 1'b0;
    mul_p    = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      mul_p    = 16'($urandom);
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          mul_done = 1'b1;
          mul_p    = core_p;
          if (o_busy === 1'b1) begin
            n_checks++;
            if ({o_mul_a, o_mul_b} !== {exp_a, exp_b}) begin
              n_errors++;
              $display("FAIL operand_stable: got %h/%h, required %h/%h", o_mul_a, o_mul_b, exp_a, exp_b);
            end
          end
        end
      end
      if (o_mul_start === 1'b1) begin
        start_count++;
        core_cnt = core_delay;
        n_checks++;
        if ({o_mul_a, o_mul_b} !== {exp_a, exp_b}) begin
          n_errors++;
          $display("FAIL operand_at_start: got %h/%h, required %h/%h", o_mul_a, o_mul_b, exp_a, exp_b);
        end
      end
    end
  end

  // Drives one full transaction and reports what was observed; callers do the comparisons.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int d, input logic [15:0] p,
                       input int stall, output logic [7:0] b0, output logic [7:0] b1, output int lat,
                       output int gap, output logic err_lo, output logic err_out, output logic hold_ok,
                       output logic busy_after, output logic rdy_after, output int starts);
    int s0;
    exp_a = a; exp_b = b; core_delay = d; core_p = p; s0 = start_count;
    hold_ok = 1'b1; gap = 0;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b1; in_a = a[7:0]; in_b = b[7:0];
    @(negedge clk);
    err_lo = o_error;
    in_a = a[15:8]; in_b = b[15:8];
    @(negedge clk);
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    lat = 1;
    while (o_out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    b0 = o_out_byte;
    err_out = o_error;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (o_out_valid !== 1'b1 || o_out_byte !== b0) hold_ok = 1'b0;
      if (i == stall - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    while (o_out_valid !== 1'b1 && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    b1 = o_out_byte;
    @(negedge clk);
    busy_after = o_busy;
    rdy_after  = o_in_ready;
    starts     = start_count - s0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({o_in_ready, o_busy, o_mul_start, o_out_valid, o_error} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, required 10000", {o_in_ready, o_busy, o_mul_start, o_out_valid, o_error});
    end
    n_checks++;
    if (o_out_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_out_byte: got %h, required 00", o_out_byte);
    end
    n_checks++;
    if ({o_mul_a, o_mul_b} !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_operands: got %h, required 0", {o_mul_a, o_mul_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    do_op(16'h3E00, 16'h4200, 2, 16'h4480, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if ({b0, b1} !== 16'h8044) begin
      n_errors++; $display("FAIL basic_bytes: got %h %h, required 80 44", b0, b1);
    end
    n_checks++;
    if ({eo, ba, ra} !== 3'b001) begin
      n_errors++; $display("FAIL basic_err_busy_ready: got %b, required 001", {eo, ba, ra});
    end
    n_checks++;
    if (lat != 4 || gap != 0 || st != 1) begin
      n_errors++; $display("FAIL basic_timing: got lat=%0d gap=%0d starts=%0d, required 4 0 1", lat, gap, st);
    end
  endtask

  task automatic test_min_latency();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    do_op(16'h1234, 16'hABCD, 1, 16'h5A3C, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if (lat != 3 || {b1, b0} !== 16'h5A3C) begin
      n_errors++; $display("FAIL min_latency: got lat=%0d result=%h, required 3 5a3c", lat, {b1, b0});
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    do_op(16'h3E00, 16'h4200, 2, 16'h4480, 10, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if (hok !== 1'b1 || b0 !== 8'h80) begin
      n_errors++; $display("FAIL backpressure_hold: got hold_ok=%b byte=%h, required 1 80", hok, b0);
    end
    n_checks++;
    if (b1 !== 8'h44 || gap != 0) begin
      n_errors++; $display("FAIL backpressure_hi: got %h gap=%0d, required 44 0", b1, gap);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    do_op(16'h3E00, 16'h4200, 0, 16'h4480, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if ({b0, b1} !== 16'h007E || eo !== 1'b1) begin
      n_errors++; $display("FAIL timeout_result: got %h %h err=%b, required 00 7e 1", b0, b1, eo);
    end
    n_checks++;
    if (st != 1 || lat != 17) begin
      n_errors++; $display("FAIL timeout_timing: got starts=%0d lat=%0d, required 1 17", st, lat);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_error !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++; $display("FAIL timeout_sticky: got err=%b busy=%b, required 1 0", o_error, o_busy);
    end
    do_op(16'h0102, 16'h0304, 3, 16'hBEEF, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if ({el, eo} !== 2'b00 || {b1, b0} !== 16'hBEEF) begin
      n_errors++; $display("FAIL error_clear: got err_lo=%b err_out=%b result=%h, required 0 0 beef", el, eo, {b1, b0});
    end
  endtask

  task automatic test_done_boundary();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    do_op(16'h3C00, 16'h3C00, 15, 16'h3C00, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if ({b1, b0} !== 16'h3C00 || eo !== 1'b0 || lat != 17) begin
      n_errors++; $display("FAIL done_at_limit: got %h err=%b lat=%0d, required 3c00 0 17", {b1, b0}, eo, lat);
    end
    do_op(16'h3C00, 16'h3C00, 16, 16'h3C00, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if ({b1, b0} !== FP16_QNAN || eo !== 1'b1 || lat != 17) begin
      n_errors++; $display("FAIL done_past_limit: got %h err=%b lat=%0d, required 7e00 1 17", {b1, b0}, eo, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    logic seen_valid, seen_busy;
    exp_a = 16'h1111; exp_b = 16'h2222; core_delay = 5; core_p = 16'h1234;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid_pre_busy: got %b, required 1", o_busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_out_valid, o_busy, o_in_ready} !== 3'b001) begin
      n_errors++; $display("FAIL reset_mid_async: got %b, required 001", {o_out_valid, o_busy, o_in_ready});
    end
    @(negedge clk); rst = 1'b0;
    seen_valid = 1'b0; seen_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (o_out_valid === 1'b1) seen_valid = 1'b1;
      if (o_busy !== 1'b0 || o_in_ready !== 1'b1) seen_busy = 1'b1;
    end
    n_checks++;
    if ({seen_valid, seen_busy} !== 2'b00) begin
      n_errors++; $display("FAIL reset_mid_quiet: got valid=%b busy=%b, required 0 0", seen_valid, seen_busy);
    end
    do_op(16'h4000, 16'h4000, 2, 16'h4400, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if ({b0, b1} !== 16'h0044 || eo !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_next: got %h %h err=%b, required 00 44 0", b0, b1, eo);
    end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    logic [15:0] a, b, p, exp_res;
    int d, stall, exp_lat;
    logic ok;
    for (int n = 0; n < 24; n++) begin
      a = 16'($urandom); b = 16'($urandom); p = 16'($urandom);
      d = $urandom_range(0, 18); stall = $urandom_range(0, 3);
      ok = (d >= 1 && d <= 15);
      exp_res = ok ? p : FP16_QNAN;
      exp_lat = (ok ? d : 15) + 2;
      do_op(a, b, d, p, stall, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
      n_checks++;
      if ({b1, b0} !== exp_res || eo !== !ok || el !== 1'b0) begin
        n_errors++;
        $display("FAIL random_%0d_result: got %h err=%b err_lo=%b, required %h %b 0", n, {b1, b0}, eo, el, exp_res, !ok);
      end
      n_checks++;
      if (lat != exp_lat || gap != 0 || st != 1 || hok !== 1'b1 || {ba, ra} !== 2'b01) begin
        n_errors++;
        $display("FAIL random_%0d_timing: got lat=%0d gap=%0d starts=%0d hold=%b busy/rdy=%b, required %0d 0 1 1 01",
                 n, lat, gap, st, hok, {ba, ra}, exp_lat);
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] b0, b1; int lat, gap, st; logic el, eo, hok, ba, ra;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sel = 1'b1;
    do_op(16'h3E00, 16'h4200, 2, 16'h4480, 0, b0, b1, lat, gap, el, eo, hok, ba, ra, st);
    n_checks++;
    if (gap != 2 || {b0, b1} !== 16'h8044) begin
      n_errors++; $display("FAIL gap_hold2: got gap=%0d bytes %h %h, required 2 80 44", gap, b0, b1);
    end
    n_checks++;
    if (lat != 4 || {eo, ba, ra} !== 3'b001) begin
      n_errors++; $display("FAIL gap_hold2_misc: got lat=%0d flags=%b, required 4 001", lat, {eo, ba, ra});
    end
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_min_latency();
    test_backpressure();
    test_timeout();
    test_done_boundary();
    test_reset_mid();
    test_random();
    test_gap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
